// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings and line levels shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
    localparam int DEFAULT_CLKS_PER_BIT = 1302;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter; bitTick marks the last cycle of each bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1302
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bitTick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        bitTick = en && cnt_q == LAST;
        cnt_d = (clr || bitTick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN to add a parity bit.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clock,
    input  logic       resetGral,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       txReady,
    output logic       txBusy,
    output logic       txDone,
    output logic       uartTxPin
);
`ifdef UART_TX_PARITY_EN
    localparam logic HAS_PARITY = 1'b1;
`else
    localparam logic HAS_PARITY = 1'b0;
`endif
    uart_state_e state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic buf_full_q, buf_full_d, par_q, par_d, pin_q, pin_d, busy_q, busy_d, done_q, done_d;
    logic bit_tick, accept, load, data_last, stop_last;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clock),
        .rst(resetGral),
        .clr(state_q == ST_IDLE),
        .en(state_q != ST_IDLE),
        .bitTick(bit_tick)
    );

    always_comb begin
        accept = txStart && !buf_full_q;
        data_last = state_q == ST_DATA && bit_tick && idx_q == 3'(DATA_BITS - 1);
        stop_last = state_q == ST_STOP && bit_tick && idx_q == 3'(STOP_BITS - 1);
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = buf_full_q ? ST_START : ST_IDLE;
            ST_START:  state_d = bit_tick ? ST_DATA : ST_START;
            ST_DATA:   state_d = data_last ? (HAS_PARITY ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY: state_d = bit_tick ? ST_STOP : ST_PARITY;
            ST_STOP:   state_d = stop_last ? (buf_full_q ? ST_START : ST_IDLE) : ST_STOP;
            default:   state_d = ST_IDLE;
        endcase
        // Entering START drains the buffer; accept needs it empty, so the two never collide.
        load = state_d == ST_START && state_q != ST_START;
        buf_d = accept ? txData : buf_q;
        buf_full_d = accept || (buf_full_q && !load);
        shift_d = load ? buf_q[DATA_BITS-1:0] : (state_q == ST_DATA && bit_tick) ? shift_q >> 1 : shift_q;
        par_d = load ? (^buf_q[DATA_BITS-1:0]) ^ (PARITY_ODD != 0) : par_q;
        idx_d = state_d != state_q ? '0 : bit_tick ? idx_q + 3'd1 : idx_q;
        // The pin lags the state by one cycle, so busy and done are aligned to the pin.
        pin_d = state_q == ST_START ? START_LEVEL : state_q == ST_DATA ? shift_q[0] :
                state_q == ST_PARITY ? par_q : IDLE_LEVEL;
        busy_d = state_q != ST_IDLE || state_d != ST_IDLE;
        done_d = stop_last;
    end

    always_ff @(posedge clock) begin
        if (resetGral) begin
            state_q <= ST_IDLE;
            buf_q <= '0;
            buf_full_q <= 1'b0;
            shift_q <= '0;
            par_q <= 1'b0;
            idx_q <= '0;
            pin_q <= IDLE_LEVEL;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q <= shift_d;
            par_q <= par_d;
            idx_q <= idx_d;
            pin_q <= pin_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign txReady = !buf_full_q;
    assign txBusy = busy_q;
    assign txDone = done_q;
    assign uartTxPin = pin_q;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: checks uart_tx_unit against a frame-level model plus literal expectations.
module tb_uart_tx_unit;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 9 + PAR;
    localparam int L = (NB + 1) * CPB;

    logic clock = 1'b0, resetGral = 1'b1, txStart = 1'b0, start2 = 1'b0;
    logic [7:0] txData = 8'h00, data2 = 8'h00;
    logic txReady, txBusy, txDone, uartTxPin, ready2, busy2, done2, pin2;
    int checks = 0, errors = 0, cyc = 0, nfr = 0;
    bit checking = 1'b0;
    int f_n[32], f_s[32];
    logic [7:0] f_d[32];
    int done_q[$];

    always #5 clock = ~clock;

    uart_tx_unit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clock(clock), .resetGral(resetGral), .txData(txData), .txStart(txStart),
        .txReady(txReady), .txBusy(txBusy), .txDone(txDone), .uartTxPin(uartTxPin)
    );

    uart_tx_unit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
        .clock(clock), .resetGral(resetGral), .txData(data2), .txStart(start2),
        .txReady(ready2), .txBusy(busy2), .txDone(done2), .uartTxPin(pin2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (PAR == 1 && i == 9) return ^d;
        return 1'b1;
    endfunction

    // {pin, ready, busy, done} expected in cycle k from the list of accepted frames
    function automatic logic [3:0] model_out(input int k);
        logic pin, rdy, bsy, dn;
        pin = 1'b1; rdy = 1'b1; bsy = 1'b0; dn = 1'b0;
        for (int i = 0; i < nfr; i++) begin
            if (k >= f_s[i] && k < f_s[i] + L) pin = frame_bit(f_d[i], (k - f_s[i]) / CPB);
            if (k >= f_s[i] - 1 && k < f_s[i] + L) bsy = 1'b1;
            if (k == f_s[i] + L - 1) dn = 1'b1;
            if (k >= f_n[i] && k <= f_s[i] - 2) rdy = 1'b0;
        end
        return {pin, rdy, bsy, dn};
    endfunction

    initial begin
        logic [3:0] m;
        int s;
        forever begin
            @(posedge clock);
            m = model_out(cyc);
            cyc++;
            if (resetGral) nfr = 0;
            else if (txStart && m[2] && nfr < 32) begin
                s = cyc + 2;
                if (nfr > 0 && f_s[nfr-1] + L > s) s = f_s[nfr-1] + L;
                f_n[nfr] = cyc;
                f_s[nfr] = s;
                f_d[nfr] = txData;
                nfr++;
            end
        end
    end

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clock);
            if (checking) begin
                e = model_out(cyc);
                chk("pin", uartTxPin, e[3]);
                chk("ready", txReady, e[2]);
                chk("busy", txBusy, e[1]);
                chk("done", txDone, e[0]);
            end
            if (txDone === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic send(input logic [7:0] d);
        txData = d;
        txStart = 1'b1;
        @(negedge clock);
        txStart = 1'b0;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    task automatic wait_fall(input string name, output int t);
        t = -1;
        for (int i = 0; i < 200 && t < 0; i++) begin
            if (uartTxPin === 1'b0) t = cyc;
            else @(negedge clock);
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL %s: line stayed high, expected a start bit within 200 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((txBusy !== 1'b0 || txReady !== 1'b1) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s: busy=%b ready=%b, expected idle within 1000 cycles", name, txBusy, txReady);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, acc, hi, lowbad, dcnt, didx;
        logic [9:0] pat;
        repeat (3) @(negedge clock);
        chk("reset pin", uartTxPin, 1);
        chk("reset ready", txReady, 1);
        chk("reset busy", txBusy, 0);
        chk("reset done", txDone, 0);
        resetGral = 1'b0;
        checking = 1'b1;
        @(negedge clock);

        // A5: 0,1,0,1,0,0,1,0,1 then stop, each level CPB cycles
        pat = 10'b1101001010;
        acc = cyc + 1;
        send(8'hA5);
        wait_fall("A5 start", t0);
        chk("A5 fall latency", t0 - acc, 2);
        for (int i = 0; i < 10; i++) begin
            wait_until(t0 + CPB * (i == 9 ? NB : i) + 2);
            chk("A5 bit", uartTxPin, pat[i]);
        end
        wait_until(t0 + L + 2);
        chk("A5 done count", done_q.size(), 1);
        if (done_q.size() > 0) chk("A5 done cycle", done_q[0] - t0, PAR ? 43 : 39);
        chk("A5 busy after", txBusy, 0);
        done_q.delete();

        // back-to-back 55 then 0F as soon as the buffer frees
        txData = 8'h55;
        txStart = 1'b1;
        @(negedge clock);
        txData = 8'h0F;
        for (int i = 0; i < 200 && txReady !== 1'b1; i++) @(negedge clock);
        @(negedge clock);
        txStart = 1'b0;
        wait_fall("b2b start", t0);
        wait_until(t0 + L);
        chk("b2b second start bit", uartTxPin, 0);
        wait_until(t0 + 2 * L + 2);
        chk("b2b done count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b first done", done_q[0] - t0, PAR ? 43 : 39);
            chk("b2b done spacing", done_q[1] - done_q[0], PAR ? 44 : 40);
        end
        done_q.delete();

        // strobe held with changing data: only ready-edge bytes go out
        txStart = 1'b1;
        for (int i = 0; i < 3 * L; i++) begin
            txData = 8'h30 + 8'(i);
            @(negedge clock);
        end
        txStart = 1'b0;
        wait_idle("held strobe idle");
        done_q.delete();

        // reset during data bit 3 of FF, then a clean 00
        send(8'hFF);
        wait_fall("FF start", t0);
        wait_until(t0 + 4 * CPB + 1);
        resetGral = 1'b1;
        @(negedge clock);
        resetGral = 1'b0;
        chk("abort pin", uartTxPin, 1);
        chk("abort ready", txReady, 1);
        chk("abort busy", txBusy, 0);
        @(negedge clock);
        acc = cyc + 1;
        send(8'h00);
        wait_fall("00 start", t0);
        chk("00 fall latency", t0 - acc, 2);
        wait_until(t0 + L + 2);
        chk("00 done count", done_q.size(), 1);
        if (done_q.size() > 0) chk("00 done cycle", done_q[0] - t0, PAR ? 43 : 39);
        done_q.delete();

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_fall("07 start", t0);
        wait_until(t0 + 9 * CPB + 2);
        chk("07 parity", uartTxPin, 1);
        wait_idle("07 idle");
        done_q.delete();
        send(8'h03);
        wait_fall("03 start", t0);
        wait_until(t0 + 9 * CPB + 2);
        chk("03 parity", uartTxPin, 0);
        wait_until(t0 + L + 2);
        if (done_q.size() > 0) chk("03 frame length", done_q[0] - t0 + 1, 44);
        else chk("03 done count", done_q.size(), 1);
        done_q.delete();
`endif

        // two stop bits on the second instance
        start2 = 1'b1;
        data2 = 8'h00;
        @(negedge clock);
        start2 = 1'b0;
        t0 = -1;
        for (int i = 0; i < 50 && t0 < 0; i++) begin
            if (pin2 === 1'b0) t0 = cyc;
            else @(negedge clock);
        end
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL stop2 start: line stayed high, expected a start bit within 50 cycles");
        end else begin
            hi = 0; lowbad = 0; dcnt = 0; didx = -1;
            for (int i = 0; i <= NB * CPB + 12; i++) begin
                if (i < NB * CPB && pin2 !== 1'b0) lowbad++;
                if (i >= NB * CPB && i < NB * CPB + 8 && pin2 === 1'b1) hi++;
                if (done2 === 1'b1) begin
                    dcnt++;
                    didx = i;
                end
                @(negedge clock);
            end
            chk("stop2 low bits", lowbad, 0);
            chk("stop2 high cycles", hi, 8);
            chk("stop2 done count", dcnt, 1);
            chk("stop2 done cycle", didx, PAR ? 47 : 43);
            chk("stop2 busy after", busy2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
